// File: rtl/seq_mult_bcd_display_pkg.sv
// Shared types and constants for the sequential multiplier / BCD display block:
// FSM encoding, segment constants and the digit-to-segment table.
package mult_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low patterns, bit0 = segment a .. bit6 = segment g; entry [0] is digit 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end else begin
            seg = SEG_BLANK;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seq_mult_bcd_display_if.sv
// Handshake and result bundle between the switch-side requester and the multiplier/display block.
interface seq_mult_bcd_display_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic [2*WIDTH-1:0]    product;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic [7*DIGITS-1:0]   seg;

    modport master (
        output start, a, b,
        input  busy, done, product, bcd, ovf, seg
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, bcd, ovf, seg
    );
endinterface

// File: rtl/seq_mult_bcd_display_seg7.sv
// Single BCD digit to active-low seven-segment pattern; values above 9 show blank.
module bcd_digit_to_seg7
    import mult_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup with blank fallback.
    always_comb begin
        seg = digit_to_seg(digit);
    end

endmodule

// File: rtl/seq_mult_bcd_display.sv
// Shift-add multiplier followed by double-dabble conversion and registered seven-segment drive.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module seq_mult_bcd_display
    import mult_bcd_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_mult_bcd_display_if.slave bus
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam int CW = $clog2(2 * WIDTH + 1);

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   count_r;
    logic [WIDTH-1:0] a_r;
    logic [PW:0]     acc_r, acc_nxt_s;
    logic [WIDTH:0]  sum_s;
    logic [PW-1:0]   bin_r, bin_nxt_s;
    logic [BW-1:0]   dab_r, dab_adj_s, dab_nxt_s;
    logic            ovf_sticky_r, ovf_nxt_s;
    logic            mul_last_s, conv_last_s;
    logic            busy_nxt_s, done_nxt_s, load_out_s;
    logic [SW-1:0]   seg_raw_s, seg_disp_s;

    logic            busy_r, done_r, ovf_r;
    logic [PW-1:0]   product_r;
    logic [BW-1:0]   bcd_r;
    logic [SW-1:0]   seg_r;

    assign mul_last_s  = (count_r == CW'(WIDTH - 1));
    assign conv_last_s = (count_r == CW'(PW - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_nxt_s = ST_MUL;
                else           state_nxt_s = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_last_s) state_nxt_s = ST_CONV;
                else            state_nxt_s = ST_MUL;
            end
            ST_CONV: begin
                if (conv_last_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_CONV;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; handshake outputs are registered one step ahead of the state.
    always_comb begin
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
        if (state_r == ST_CONV) begin
            load_out_s = conv_last_s;
        end else begin
            load_out_s = 1'b0;
        end
    end

    // Multiplier step: b sits in the low half of acc and is consumed LSB first while the
    // upper half accumulates; the extra top bit keeps the carry until it is shifted down.
    always_comb begin
        sum_s     = acc_r[PW:WIDTH] + {1'b0, a_r & {WIDTH{acc_r[0]}}};
        acc_nxt_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
    end

    // Double-dabble iteration: adjust digits >= 5, then shift one binary bit in.
    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            if (dab_r[4*d +: 4] >= 4'd5) begin
                dab_adj_s[4*d +: 4] = dab_r[4*d +: 4] + 4'd3;
            end else begin
                dab_adj_s[4*d +: 4] = dab_r[4*d +: 4];
            end
        end
        dab_nxt_s = {dab_adj_s[BW-2:0], bin_r[PW-1]};
        bin_nxt_s = {bin_r[PW-2:0], 1'b0};
        ovf_nxt_s = ovf_sticky_r | dab_adj_s[BW-1];
    end

    // Datapath registers: operand capture, accumulation and conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r      <= {CW{1'b0}};
            a_r          <= {WIDTH{1'b0}};
            acc_r        <= {(PW+1){1'b0}};
            bin_r        <= {PW{1'b0}};
            dab_r        <= {BW{1'b0}};
            ovf_sticky_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        acc_r   <= {{(WIDTH+1){1'b0}}, bus.b};
                        count_r <= {CW{1'b0}};
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_nxt_s;
                    if (mul_last_s) begin
                        count_r      <= {CW{1'b0}};
                        bin_r        <= acc_nxt_s[PW-1:0];
                        dab_r        <= {BW{1'b0}};
                        ovf_sticky_r <= 1'b0;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ST_CONV: begin
                    bin_r        <= bin_nxt_s;
                    dab_r        <= dab_nxt_s;
                    ovf_sticky_r <= ovf_nxt_s;
                    count_r      <= count_r + CW'(1);
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_digit_to_seg7 u_seg (
            .digit (dab_nxt_s[4*g +: 4]),
            .seg   (seg_raw_s[7*g +: 7])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen_s;

    // Blank zero digits above the most significant non-zero digit; digit 0 always shows.
    always_comb begin
        seg_disp_s = seg_raw_s;
        nz_seen_s  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (dab_nxt_s[4*i +: 4] != 4'd0) nz_seen_s = 1'b1;
            else                             nz_seen_s = nz_seen_s;
            if (!nz_seen_s) seg_disp_s[7*i +: 7] = SEG_BLANK;
            else            seg_disp_s[7*i +: 7] = seg_raw_s[7*i +: 7];
        end
    end
`else
    // All digits displayed, leading zeros included.
    always_comb begin
        seg_disp_s = seg_raw_s;
    end
`endif

    // Output registers; results are loaded on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {PW{1'b0}};
            bcd_r     <= {BW{1'b0}};
            ovf_r     <= 1'b0;
            seg_r     <= {DIGITS{SEG_ZERO}};
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (load_out_s) begin
                product_r <= acc_r[PW-1:0];
                bcd_r     <= dab_nxt_s;
                ovf_r     <= ovf_nxt_s;
                seg_r     <= seg_disp_s;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign bus.bcd     = bcd_r;
    assign bus.ovf     = ovf_r;
    assign bus.seg     = seg_r;

endmodule

// File: tb/tb_seq_mult_bcd_display.sv
// Directed bench for seq_mult_bcd_display: a 3-digit and a 2-digit instance share stimulus and
// are compared every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_seq_mult_bcd_display;

    localparam int W = 4;

    typedef struct {
        int         prod;
        logic [11:0] bcd;
        logic       ovf;
        logic [20:0] seg;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [W-1:0] a, b;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   lat;

    int   m_cnt [2];
    int   p_a [2];
    int   p_b [2];
    res_t e_res [2];

    always #5 clk = ~clk;

    seq_mult_bcd_display_if #(.WIDTH(W), .DIGITS(3)) bus3 ();
    seq_mult_bcd_display_if #(.WIDTH(W), .DIGITS(2)) bus2 ();

    assign bus3.start = start;
    assign bus3.a     = a;
    assign bus3.b     = b;
    assign bus2.start = start;
    assign bus2.a     = a;
    assign bus2.b     = b;

    seq_mult_bcd_display #(.WIDTH(W), .DIGITS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));
    seq_mult_bcd_display #(.WIDTH(W), .DIGITS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic res_t compute(input int av, input int bv, input int digits);
        res_t r;
        int   p, m, pw, tmp, dv, msd;
        p   = av * bv;
        pw  = 1;
        for (int i = 0; i < digits; i++) pw = pw * 10;
        m      = p % pw;
        r.prod = p;
        r.ovf  = (p >= pw);
        r.bcd  = '0;
        r.seg  = '0;
        msd    = 0;
        tmp    = m;
        for (int i = 0; i < digits; i++) begin
            dv = tmp % 10;
            tmp = tmp / 10;
            r.bcd[4*i +: 4] = 4'(dv);
            if (dv != 0) msd = i;
        end
        for (int i = 0; i < digits; i++) begin
            r.seg[7*i +: 7] = pat(int'(r.bcd[4*i +: 4]));
`ifdef LEADING_ZERO_BLANK_EN
            if (i > msd) r.seg[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    function automatic res_t reset_res(input int digits);
        res_t r;
        r.prod = 0;
        r.bcd  = '0;
        r.ovf  = 1'b0;
        r.seg  = '0;
        for (int i = 0; i < digits; i++) r.seg[7*i +: 7] = 7'h40;
        return r;
    endfunction

    // Model: idle when the countdown is 0; an accepted request takes 3*W+1 cycles to done.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_cnt[k] <= 0;
                e_res[k] <= reset_res(3 - k);
            end else if (m_cnt[k] == 0) begin
                if (start) begin
                    m_cnt[k] <= 3 * W + 1;
                    p_a[k]   <= int'(a);
                    p_b[k]   <= int'(b);
                end
            end else begin
                m_cnt[k] <= m_cnt[k] - 1;
                if (m_cnt[k] == 2) e_res[k] <= compute(p_a[k], p_b[k], 3 - k);
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy3", bus3.busy, m_cnt[0] != 0);
            check("done3", bus3.done, m_cnt[0] == 1);
            check("prod3", bus3.product, e_res[0].prod);
            check("bcd3",  bus3.bcd, e_res[0].bcd);
            check("ovf3",  bus3.ovf, e_res[0].ovf);
            check("seg3",  bus3.seg, e_res[0].seg);
            check("busy2", bus2.busy, m_cnt[1] != 0);
            check("done2", bus2.done, m_cnt[1] == 1);
            check("prod2", bus2.product, e_res[1].prod);
            check("bcd2",  bus2.bcd, e_res[1].bcd[7:0]);
            check("ovf2",  bus2.ovf, e_res[1].ovf);
            check("seg2",  bus2.seg, e_res[1].seg[13:0]);
        end
    end

    // Start held during cycle 0; returns the cycle index at which done was seen (-1 on timeout),
    // then waits one more cycle so the block is back in IDLE.
    task automatic run_op(input int av, input int bv, input bit pulses, output int l);
        a = W'(av);
        b = W'(bv);
        start = 1'b1;
        l = -1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus3.done) begin
                l = c;
                start = 1'b0;
                break;
            end
            if (pulses && (c == 3 || c == 12)) begin
                a = W'(c);
                b = W'(c + 1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", bus3.busy, 1'b0);
        check("rst_prod", bus3.product, 8'd0);
        check("rst_seg3", bus3.seg, {7'h40, 7'h40, 7'h40});
        reset = 1'b0;
        @(negedge clk);

        run_op(15, 15, 1'b1, lat);
        check("latency", lat, 3 * W + 1);
        check("p15x15", bus3.product, 8'd225);
        check("b15x15", bus3.bcd, 12'h225);
        check("o15x15", bus3.ovf, 1'b0);
        check("s15x15", bus3.seg, {7'h24, 7'h24, 7'h12});
        check("b15x15_d2", bus2.bcd, 8'h25);
        check("o15x15_d2", bus2.ovf, 1'b1);

        run_op(9, 11, 1'b0, lat);
        check("lat_b2b", lat, 3 * W + 1);
        check("p9x11_d2", bus2.product, 8'd99);
        check("o9x11_d2", bus2.ovf, 1'b0);
        check("b9x11", bus3.bcd, 12'h099);

        run_op(0, 9, 1'b0, lat);
        check("p0x9", bus3.product, 8'd0);
        check("b0x9", bus3.bcd, 12'h000);
`ifdef LEADING_ZERO_BLANK_EN
        check("s0x9", bus3.seg, {7'h7F, 7'h7F, 7'h40});
`else
        check("s0x9", bus3.seg, {7'h40, 7'h40, 7'h40});
`endif

        run_op(7, 8, 1'b0, lat);
        check("p7x8", bus3.product, 8'd56);
        check("b7x8", bus3.bcd, 12'h056);
`ifdef LEADING_ZERO_BLANK_EN
        check("s7x8", bus3.seg, {7'h7F, 7'h12, 7'h02});
`else
        check("s7x8", bus3.seg, {7'h40, 7'h12, 7'h02});
`endif

        // Reset in the middle of an operation discards the result.
        a = 4'd5;
        b = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", bus3.busy, 1'b0);
        check("midrst_prod", bus3.product, 8'd0);
        check("midrst_seg", bus3.seg, {7'h40, 7'h40, 7'h40});
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus3.done) seen++;
            @(negedge clk);
        end
        check("midrst_nodone", seen, 0);

        // Reset and start together: start must not be accepted.
        a = 4'd3;
        b = 4'd3;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_start_busy", bus3.busy, 1'b0);
        @(negedge clk);
        check("rst_start_busy2", bus3.busy, 1'b0);

        run_op(1, 1, 1'b0, lat);
        run_op(15, 1, 1'b0, lat);
        run_op(10, 10, 1'b0, lat);
        check("b10x10_d2", bus2.bcd, 8'h00);
        check("o10x10_d2", bus2.ovf, 1'b1);
        run_op(12, 13, 1'b0, lat);
        check("b12x13", bus3.bcd, 12'h156);
        run_op(8, 8, 1'b0, lat);
        check("p8x8", bus3.product, 8'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
